// File: rtl/inv_skew_detector_pkg.sv
// Shared definitions for the inverter-chain skew detector: decision encodings,
// FSM state type and the window classification helper.
package inv_skew_detector_pkg;

  localparam logic [1:0] DEC_HOLD = 2'b00;
  localparam logic [1:0] DEC_UP   = 2'b10;
  localparam logic [1:0] DEC_DN   = 2'b01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DECIDE  = 2'd2
  } state_e;

  // A saturated window carries no trustworthy frequency information, so it never steers.
  function automatic logic [1:0] classify_diff(input logic sat, input int diff, input int deadband);
    logic [1:0] dec;
    if (sat) begin
      dec = DEC_HOLD;
    end else if (diff > deadband) begin
      dec = DEC_UP;
    end else if (diff < -deadband) begin
      dec = DEC_DN;
    end else begin
      dec = DEC_HOLD;
    end
    return dec;
  endfunction

endpackage

// File: rtl/inv_skew_detector_sync_edge.sv
// Synchronizer plus rising-edge detector for one asynchronous chain output.
// The history is marked invalid while clr is high so the first sample after it drops never counts.
module inv_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic chain,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;
  logic                   hist_vld_r;

  // synchronizer chain, previous-sample history and history-valid flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_r     <= '0;
      hist_r     <= 1'b0;
      hist_vld_r <= 1'b0;
    end else begin
      sync_r     <= {sync_r[SYNC_STAGES-2:0], chain};
      hist_r     <= sync_r[SYNC_STAGES-1];
      hist_vld_r <= ~clr;
    end
  end

  assign rise = hist_vld_r & sync_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/inv_skew_detector.sv
// Counts up/down inverter-chain edges over a fixed window, compares them and drives the
// one-hot O_INVU/O_INVD feedback, plus a lock flag once the chains stay matched.
module inv_skew_detector
  import inv_skew_detector_pkg::*;
#(
  parameter int WIN_CYCLES   = 256,
  parameter int CNT_W        = 10,
  parameter int DEADBAND     = 2,
  parameter int LOCK_WINDOWS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CHAIN_U,
  input  logic             CHAIN_D,
  output logic             O_INVU,
  output logic             O_INVD,
  output logic             DEC_VALID,
  output logic             LOCKED,
  output logic [CNT_W-1:0] CNT_U_LAST,
  output logic [CNT_W-1:0] CNT_D_LAST
);

  localparam int WIN_W  = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int LOCK_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
  localparam logic [WIN_W-1:0]  WIN_ONE   = WIN_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_WINDOWS);
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

  state_e               state_r;
  state_e               state_nxt_s;
  logic [WIN_W-1:0]     win_cnt_r;
  logic [CNT_W-1:0]     cnt_u_r;
  logic [CNT_W-1:0]     cnt_d_r;
  logic                 sat_u_r;
  logic                 sat_d_r;
  logic                 rise_u_s;
  logic                 rise_d_s;
  logic                 clr_s;
  logic signed [CNT_W:0] diff_s;
  logic [1:0]           dec_s;
  logic                 matched_s;
  logic [LOCK_W-1:0]    lock_nxt_s;
  logic [LOCK_W-1:0]    lock_cnt_r;
  logic [1:0]           dec_r;
  logic                 dec_valid_r;
  logic                 locked_r;
  logic [CNT_W-1:0]     cnt_u_last_r;
  logic [CNT_W-1:0]     cnt_d_last_r;

  assign clr_s = (state_r == IDLE);

  inv_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_u (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (clr_s),
    .chain (CHAIN_U),
    .rise  (rise_u_s)
  );

  inv_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_d (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (clr_s),
    .chain (CHAIN_D),
    .rise  (rise_d_s)
  );

  // window sequencing: back-to-back windows separated only by the DECIDE cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (EN) state_nxt_s = MEASURE;
        else    state_nxt_s = IDLE;
      end
      MEASURE: begin
        if (!EN)                         state_nxt_s = IDLE;
        else if (win_cnt_r == WIN_LAST)  state_nxt_s = DECIDE;
        else                             state_nxt_s = MEASURE;
      end
      DECIDE: begin
        if (EN) state_nxt_s = MEASURE;
        else    state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // window compare; the extra bit keeps the difference signed without overflow
  always_comb begin
    diff_s    = $signed({1'b0, cnt_u_r}) - $signed({1'b0, cnt_d_r});
    dec_s     = classify_diff(sat_u_r | sat_d_r, int'(diff_s), DEADBAND);
    matched_s = ~(sat_u_r | sat_d_r) && (dec_s == DEC_HOLD);
    if (!matched_s) begin
      lock_nxt_s = '0;
    end else if (lock_cnt_r == LOCK_FULL) begin
      lock_nxt_s = LOCK_FULL;
    end else begin
      lock_nxt_s = lock_cnt_r + LOCK_ONE;
    end
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // window counter and saturating edge counters; cleared outside MEASURE
  always_ff @(posedge CLK) begin
    if (RST) begin
      win_cnt_r <= '0;
      cnt_u_r   <= '0;
      cnt_d_r   <= '0;
      sat_u_r   <= 1'b0;
      sat_d_r   <= 1'b0;
    end else if (state_r == MEASURE) begin
      win_cnt_r <= (win_cnt_r == WIN_LAST) ? '0 : win_cnt_r + WIN_ONE;
      if (rise_u_s) begin
        if (cnt_u_r == CNT_MAX) sat_u_r <= 1'b1;
        else                    cnt_u_r <= cnt_u_r + CNT_ONE;
      end
      if (rise_d_s) begin
        if (cnt_d_r == CNT_MAX) sat_d_r <= 1'b1;
        else                    cnt_d_r <= cnt_d_r + CNT_ONE;
      end
    end else begin
      win_cnt_r <= '0;
      cnt_u_r   <= '0;
      cnt_d_r   <= '0;
      sat_u_r   <= 1'b0;
      sat_d_r   <= 1'b0;
    end
  end

  // decision, lock and last-count outputs; an aborted window drops decision and lock
  always_ff @(posedge CLK) begin
    if (RST) begin
      dec_r        <= DEC_HOLD;
      dec_valid_r  <= 1'b0;
      lock_cnt_r   <= '0;
      locked_r     <= 1'b0;
      cnt_u_last_r <= '0;
      cnt_d_last_r <= '0;
    end else begin
      case (state_r)
        DECIDE: begin
          dec_r        <= dec_s;
          dec_valid_r  <= 1'b1;
          lock_cnt_r   <= lock_nxt_s;
          locked_r     <= (lock_nxt_s == LOCK_FULL);
          cnt_u_last_r <= cnt_u_r;
          cnt_d_last_r <= cnt_d_r;
        end
        MEASURE: begin
          dec_valid_r <= 1'b0;
          if (!EN) begin
            dec_r      <= DEC_HOLD;
            lock_cnt_r <= '0;
            locked_r   <= 1'b0;
          end
        end
        default: dec_valid_r <= 1'b0;
      endcase
    end
  end

  assign O_INVU     = dec_r[1];
  assign O_INVD     = dec_r[0];
  assign DEC_VALID  = dec_valid_r;
  assign LOCKED     = locked_r;
  assign CNT_U_LAST = cnt_u_last_r;
  assign CNT_D_LAST = cnt_d_last_r;

endmodule

// File: tb/tb_inv_skew_detector.sv
// Self-checking bench for inv_skew_detector: scoreboard of expected window decisions,
// one task per scenario, plus a CNT_W=4 instance for the saturation case.
`timescale 1ns/1ps
module tb_inv_skew_detector;
  import inv_skew_detector_pkg::*;

  localparam int WIN = 256;

  typedef struct {
    logic [1:0] dec;
    int         per_u;
    int         per_d;
    logic       locked;
    int         cnt_fix;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic EN = 1'b0;
  logic EN_SAT = 1'b0;
  logic chain_u = 1'b0;
  logic chain_d = 1'b0;

  logic       o_invu, o_invd, dec_valid, locked;
  logic [9:0] cnt_u_last, cnt_d_last;
  logic       s_invu, s_invd, s_valid, s_locked;
  logic [3:0] s_cnt_u, s_cnt_d;

  int total = 0;
  int bad = 0;
  int half_u = 40;
  int half_d = 50;
  int lk_main = 0;
  bit both_seen = 1'b0;
  exp_t sb[$];
  exp_t sb_sat[$];

  inv_skew_detector dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CHAIN_U(chain_u), .CHAIN_D(chain_d),
    .O_INVU(o_invu), .O_INVD(o_invd), .DEC_VALID(dec_valid), .LOCKED(locked),
    .CNT_U_LAST(cnt_u_last), .CNT_D_LAST(cnt_d_last)
  );

  inv_skew_detector #(.CNT_W(4)) dut_sat (
    .CLK(CLK), .RST(RST), .EN(EN_SAT), .CHAIN_U(chain_u), .CHAIN_D(chain_d),
    .O_INVU(s_invu), .O_INVD(s_invd), .DEC_VALID(s_valid), .LOCKED(s_locked),
    .CNT_U_LAST(s_cnt_u), .CNT_D_LAST(s_cnt_d)
  );

  always #5 CLK = ~CLK;

  initial begin
    #7;
    forever begin
      #(half_u) chain_u = ~chain_u;
    end
  end

  initial begin
    #7;
    forever begin
      #(half_d) chain_d = ~chain_d;
    end
  end

  always @(negedge CLK) begin
    if ((o_invu === 1'b1 && o_invd === 1'b1) || (s_invu === 1'b1 && s_invd === 1'b1)) both_seen = 1'b1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] model_dec(input int nu, input int nd);
    if (nu - nd > 2)      return DEC_UP;
    else if (nd - nu > 2) return DEC_DN;
    else                  return DEC_HOLD;
  endfunction

  // periods in CLK cycles; nominal counts are WIN/period
  task automatic push_exp(input int pu, input int pd, input bit sat);
    exp_t e;
    e.per_u = pu;
    e.per_d = pd;
    if (sat) begin
      e.dec = DEC_HOLD;
      e.locked = 1'b0;
      e.cnt_fix = 15;
      sb_sat.push_back(e);
    end else begin
      e.dec = model_dec(WIN / pu, WIN / pd);
      if (e.dec == DEC_HOLD) lk_main = (lk_main < 4) ? lk_main + 1 : 4;
      else                   lk_main = 0;
      e.locked = (lk_main == 4);
      e.cnt_fix = -1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_dec(input bit sat, input int max_cycles, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge CLK);
      if ((sat ? s_valid : dec_valid) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    EN = 1'b0;
    EN_SAT = 1'b0;
    repeat (12) @(negedge CLK);
    RST = 1'b0;
    lk_main = 0;
    sb.delete();
    sb_sat.delete();
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    EN = 1'b1;
    repeat (3) @(negedge CLK);
    total += 5;
    if ({o_invu, o_invd} !== 2'b00) begin bad++; $display("FAIL reset_dec: got %b want 00", {o_invu, o_invd}); end
    if (dec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
    if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    if (cnt_u_last !== 10'd0 || cnt_d_last !== 10'd0) begin
      bad++; $display("FAIL reset_cnt: got u=%0d d=%0d want 0 0", cnt_u_last, cnt_d_last);
    end
    if ({s_invu, s_invd, s_valid, s_locked} !== 4'b0000) begin
      bad++; $display("FAIL reset_sat_inst: got %b want 0000", {s_invu, s_invd, s_valid, s_locked});
    end
    EN = 1'b0;
  endtask

  task automatic test_up_faster();
    exp_t e;
    bit got;
    half_u = 40; half_d = 50;
    do_reset();
    EN = 1'b1;
    push_exp(8, 10, 1'b0);
    push_exp(8, 10, 1'b0);
    for (int w = 0; w < 2; w++) begin
      wait_dec(1'b0, WIN + 20, got);
      e = sb.pop_front();
      total++;
      if (!got) begin bad++; $display("FAIL up_timeout: window %0d got no DEC_VALID want pulse", w); continue; end
      total += 2;
      if ({o_invu, o_invd} !== e.dec) begin bad++; $display("FAIL up_dec: got %b want %b", {o_invu, o_invd}, e.dec); end
      if (locked !== e.locked) begin bad++; $display("FAIL up_locked: got %b want %b", locked, e.locked); end
      if (w == 0) begin
        total += 2;
        if ((int'(cnt_u_last) * e.per_u - WIN) > e.per_u || (WIN - int'(cnt_u_last) * e.per_u) > e.per_u) begin
          bad++; $display("FAIL up_cnt_u: got %0d want %0d+/-1", cnt_u_last, WIN / e.per_u);
        end
        if ((int'(cnt_d_last) * e.per_d - WIN) > e.per_d || (WIN - int'(cnt_d_last) * e.per_d) > e.per_d) begin
          bad++; $display("FAIL up_cnt_d: got %0d want 25..26", cnt_d_last);
        end
      end
    end
  endtask

  task automatic test_dn_faster();
    exp_t e;
    bit got;
    half_u = 50; half_d = 40;
    do_reset();
    EN = 1'b1;
    for (int w = 0; w < 3; w++) push_exp(10, 8, 1'b0);
    for (int w = 0; w < 3; w++) begin
      wait_dec(1'b0, WIN + 20, got);
      e = sb.pop_front();
      total++;
      if (!got) begin bad++; $display("FAIL dn_timeout: window %0d got no DEC_VALID want pulse", w); continue; end
      total += 2;
      if ({o_invu, o_invd} !== e.dec) begin bad++; $display("FAIL dn_dec: got %b want %b", {o_invu, o_invd}, e.dec); end
      if (locked !== e.locked) begin bad++; $display("FAIL dn_locked: got %b want %b", locked, e.locked); end
    end
    total++;
    if (both_seen !== 1'b0) begin bad++; $display("FAIL onehot: got both O_INVU and O_INVD high want never"); end
  endtask

  task automatic test_lock();
    exp_t e;
    bit got;
    half_u = 40; half_d = 40;
    do_reset();
    EN = 1'b1;
    for (int w = 0; w < 4; w++) push_exp(8, 8, 1'b0);
    for (int w = 0; w < 5; w++) begin
      wait_dec(1'b0, WIN + 20, got);
      if (w == 3) begin
        half_d = 50;
        push_exp(8, 10, 1'b0);
      end
      e = sb.pop_front();
      total++;
      if (!got) begin bad++; $display("FAIL lock_timeout: window %0d got no DEC_VALID want pulse", w); continue; end
      total += 2;
      if ({o_invu, o_invd} !== e.dec) begin bad++; $display("FAIL lock_dec w%0d: got %b want %b", w, {o_invu, o_invd}, e.dec); end
      if (locked !== e.locked) begin bad++; $display("FAIL lock_locked w%0d: got %b want %b", w, locked, e.locked); end
    end
  endtask

  // continues straight from test_lock: DUT is in cycle win_cnt=0 with decision 10
  task automatic test_en_drop();
    exp_t e;
    int seen;
    int lat;
    repeat (100) @(negedge CLK);
    EN = 1'b0;
    lk_main = 0;
    @(negedge CLK);
    total += 3;
    if ({o_invu, o_invd} !== 2'b00) begin bad++; $display("FAIL drop_dec: got %b want 00", {o_invu, o_invd}); end
    if (locked !== 1'b0) begin bad++; $display("FAIL drop_locked: got %b want 0", locked); end
    if (dec_valid !== 1'b0) begin bad++; $display("FAIL drop_valid: got %b want 0", dec_valid); end
    seen = 0;
    for (int i = 0; i < WIN + 50; i++) begin
      @(negedge CLK);
      if (dec_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL drop_no_pulse: got %0d pulses want 0", seen); end
    push_exp(8, 10, 1'b0);
    EN = 1'b1;
    lat = 0;
    for (int i = 1; i <= WIN + 20; i++) begin
      @(negedge CLK);
      if (dec_valid === 1'b1) begin lat = i; break; end
    end
    e = sb.pop_front();
    total += 2;
    if (lat != WIN + 2) begin bad++; $display("FAIL restart_latency: got %0d want %0d", lat, WIN + 2); end
    if ({o_invu, o_invd} !== e.dec) begin bad++; $display("FAIL restart_dec: got %b want %b", {o_invu, o_invd}, e.dec); end
  endtask

  task automatic test_saturation();
    exp_t e;
    bit got;
    half_u = 40; half_d = 40;
    do_reset();
    EN_SAT = 1'b1;
    for (int w = 0; w < 4; w++) push_exp(8, 8, 1'b1);
    for (int w = 0; w < 4; w++) begin
      wait_dec(1'b1, WIN + 20, got);
      e = sb_sat.pop_front();
      total++;
      if (!got) begin bad++; $display("FAIL sat_timeout: window %0d got no DEC_VALID want pulse", w); continue; end
      total += 3;
      if ({s_invu, s_invd} !== e.dec) begin bad++; $display("FAIL sat_dec: got %b want %b", {s_invu, s_invd}, e.dec); end
      if (int'(s_cnt_u) != e.cnt_fix || int'(s_cnt_d) != e.cnt_fix) begin
        bad++; $display("FAIL sat_cnt: got u=%0d d=%0d want %0d", s_cnt_u, s_cnt_d, e.cnt_fix);
      end
      if (s_locked !== e.locked) begin bad++; $display("FAIL sat_locked w%0d: got %b want %b", w, s_locked, e.locked); end
    end
    EN_SAT = 1'b0;
  endtask

  task automatic test_rst_in_decide();
    exp_t e;
    bit got;
    int lat;
    half_u = 40; half_d = 50;
    do_reset();
    EN = 1'b1;
    push_exp(8, 10, 1'b0);
    wait_dec(1'b0, WIN + 20, got);
    e = sb.pop_front();
    total += 2;
    if (!got) begin bad++; $display("FAIL rstd_timeout: got no DEC_VALID want pulse"); end
    if ({o_invu, o_invd} !== e.dec) begin bad++; $display("FAIL rstd_dec: got %b want %b", {o_invu, o_invd}, e.dec); end
    repeat (WIN) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    lk_main = 0;
    total += 3;
    if (dec_valid !== 1'b0) begin bad++; $display("FAIL rstd_valid: got %b want 0", dec_valid); end
    if ({o_invu, o_invd, locked} !== 3'b000) begin bad++; $display("FAIL rstd_out: got %b want 000", {o_invu, o_invd, locked}); end
    if (cnt_u_last !== 10'd0 || cnt_d_last !== 10'd0) begin
      bad++; $display("FAIL rstd_cnt: got u=%0d d=%0d want 0 0", cnt_u_last, cnt_d_last);
    end
    push_exp(8, 10, 1'b0);
    lat = 0;
    for (int i = 1; i <= WIN + 20; i++) begin
      @(negedge CLK);
      if (dec_valid === 1'b1) begin lat = i; break; end
    end
    e = sb.pop_front();
    total += 2;
    if (lat != WIN + 2) begin bad++; $display("FAIL rstd_idle_latency: got %0d want %0d", lat, WIN + 2); end
    if ({o_invu, o_invd} !== e.dec) begin bad++; $display("FAIL rstd_redec: got %b want %b", {o_invu, o_invd}, e.dec); end
  endtask

  initial begin
    test_reset();
    test_up_faster();
    test_dn_faster();
    test_lock();
    test_en_drop();
    test_saturation();
    test_rst_in_decide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
